// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq: registered ALU with valid/ready handshakes, status flags and an
// iterative shift-add unsigned multiplier. Only one operation is in flight at a
// time. Single-cycle ops complete on the accept edge. Multiply runs for WIDTH
// cycles before its result is presented.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst        - synchronous active-high reset, priority over handshakes
//   in_valid   - op/a/b valid this cycle
//   in_ready   - block can accept an operation (IDLE only)
//   op         - opcode: 1 add, 2 sub, 3 and, 4 or, 5 xor, 6 not a, 7 shl,
//                8 shr, 9 eq, 10 mul, 11 ltu; others are illegal
//   a, b       - operands (b is the shift amount for shifts)
//   out_valid  - result/flags valid, held until out_ready
//   out_ready  - sink accepts the result this cycle
//   result     - result (low half of the product for multiply)
//   result_hi  - high half of the product, 0 for other ops
//   flag_zero  - result is zero (full product for multiply)
//   flag_carry - add carry-out, sub borrow, multiply high half non-zero
//   flag_neg   - result MSB
//   flag_ovf   - signed overflow for add/sub
//   flag_err   - illegal opcode
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_neg,
  output logic             flag_ovf,
  output logic             flag_err
);

  localparam int               CNT_W     = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_r;
  logic                 in_ready_r;
  logic                 out_valid_r;
  logic [WIDTH-1:0]     result_r;
  logic [WIDTH-1:0]     result_hi_r;
  logic                 zero_r, carry_r, neg_r, ovf_r, err_r;

  // Multiplier datapath: shifted multiplicand, consumed multiplier, partial sum
  logic [2*WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]     mplier_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [CNT_W-1:0]     cnt_r;

  logic [WIDTH:0]       sum_s;
  logic [WIDTH:0]       diff_s;
  logic [WIDTH-1:0]     alu_res_s;
  logic                 alu_zero_s, alu_carry_s, alu_neg_s, alu_ovf_s, alu_err_s;
  logic [2*WIDTH-1:0]   acc_next_s;

  // Single-cycle ALU result and flags, computed straight from the input operands
  always_comb begin
    sum_s       = {1'b0, a} + {1'b0, b};
    diff_s      = {1'b0, a} - {1'b0, b};
    alu_res_s   = {WIDTH{1'b0}};
    alu_carry_s = 1'b0;
    alu_ovf_s   = 1'b0;
    alu_err_s   = 1'b0;
    case (op)
      4'd1: begin
        alu_res_s   = sum_s[WIDTH-1:0];
        alu_carry_s = sum_s[WIDTH];
        // Overflow: like-signed operands giving an opposite-signed sum
        alu_ovf_s   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      4'd2: begin
        alu_res_s   = diff_s[WIDTH-1:0];
        alu_carry_s = diff_s[WIDTH];
        alu_ovf_s   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
      end
      4'd3: alu_res_s = a & b;
      4'd4: alu_res_s = a | b;
      4'd5: alu_res_s = a ^ b;
      4'd6: alu_res_s = ~a;
      // The whole shift amount is compared so large b never wraps around
      4'd7: begin
        if (b >= SHIFT_LIM) begin
          alu_res_s = {WIDTH{1'b0}};
        end else begin
          alu_res_s = a << b;
        end
      end
      4'd8: begin
        if (b >= SHIFT_LIM) begin
          alu_res_s = {WIDTH{1'b0}};
        end else begin
          alu_res_s = a >> b;
        end
      end
      4'd9:  alu_res_s = {{(WIDTH-1){1'b0}}, (a == b)};
      4'd10: alu_res_s = {WIDTH{1'b0}};  // handled by the multiplier
      4'd11: alu_res_s = {{(WIDTH-1){1'b0}}, (a < b)};
      default: alu_err_s = 1'b1;
    endcase
    // Illegal opcodes report only the error flag
    alu_zero_s = !alu_err_s && (alu_res_s == {WIDTH{1'b0}});
    alu_neg_s  = !alu_err_s && alu_res_s[WIDTH-1];
  end

  // Next partial sum for the multiplier bit currently at mplier_r[0]
  always_comb begin
    if (mplier_r[0]) begin
      acc_next_s = acc_r + mcand_r;
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Handshake FSM, multiplier sequencing and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      result_hi_r <= {WIDTH{1'b0}};
      zero_r      <= 1'b0;
      carry_r     <= 1'b0;
      neg_r       <= 1'b0;
      ovf_r       <= 1'b0;
      err_r       <= 1'b0;
      mcand_r     <= {(2*WIDTH){1'b0}};
      mplier_r    <= {WIDTH{1'b0}};
      acc_r       <= {(2*WIDTH){1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            in_ready_r <= 1'b0;
            if (op == 4'd10) begin
              mcand_r  <= {{WIDTH{1'b0}}, a};
              mplier_r <= b;
              acc_r    <= {(2*WIDTH){1'b0}};
              cnt_r    <= {CNT_W{1'b0}};
              state_r  <= ST_MUL;
            end else begin
              result_r    <= alu_res_s;
              result_hi_r <= {WIDTH{1'b0}};
              zero_r      <= alu_zero_s;
              carry_r     <= alu_carry_s;
              neg_r       <= alu_neg_s;
              ovf_r       <= alu_ovf_s;
              err_r       <= alu_err_s;
              out_valid_r <= 1'b1;
              state_r     <= ST_DONE;
            end
          end
        end
        ST_MUL: begin
          // The last multiplier bit is folded in on the same edge the product is registered
          if (cnt_r == LAST_STEP) begin
            result_r    <= acc_next_s[WIDTH-1:0];
            result_hi_r <= acc_next_s[2*WIDTH-1:WIDTH];
            zero_r      <= (acc_next_s == {(2*WIDTH){1'b0}});
            carry_r     <= (acc_next_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
            neg_r       <= acc_next_s[WIDTH-1];
            ovf_r       <= 1'b0;
            err_r       <= 1'b0;
            out_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            acc_r    <= acc_next_s;
            mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            cnt_r    <= cnt_r + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign result     = result_r;
  assign result_hi  = result_hi_r;
  assign flag_zero  = zero_r;
  assign flag_carry = carry_r;
  assign flag_neg   = neg_r;
  assign flag_ovf   = ovf_r;
  assign flag_err   = err_r;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq: directed test of alu_seq (WIDTH=8). A queue-based reference
// model predicts in_ready/out_valid timing and the result/flags of every
// accepted operation; a negedge monitor compares the DUT against it each
// cycle. Directed vectors also carry hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op;
  logic [7:0] a, b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result, result_hi;
  logic       flag_zero, flag_carry, flag_neg, flag_ovf, flag_err;
  logic [4:0] flags;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit armed    = 1'b0;

  typedef struct {
    logic [7:0] r;
    logic [7:0] h;
    logic [4:0] f;   // {zero, carry, neg, ovf, err}
    int         due; // monitor cycle from which out_valid must be high
  } exp_t;

  exp_t q[$];
  bit   busy_m, ov_m;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .flag_zero(flag_zero),
    .flag_carry(flag_carry), .flag_neg(flag_neg), .flag_ovf(flag_ovf),
    .flag_err(flag_err)
  );

  assign flags = {flag_zero, flag_carry, flag_neg, flag_ovf, flag_err};

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values
  function automatic exp_t model(input logic [3:0] o, input logic [7:0] x,
                                 input logic [7:0] y, input int now);
    exp_t e;
    int ua, ub, sa, sb, s, r, p;
    logic z, c, n, v, er;
    ua = int'(x); ub = int'(y);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    r = 0; p = 0; c = 1'b0; v = 1'b0; er = 1'b0;
    e.h = 8'h00;
    case (o)
      4'd1: begin r = ua + ub; c = (r > 255); s = sa + sb; v = (s > 127) || (s < -128); end
      4'd2: begin r = ua - ub; c = (ua < ub); s = sa - sb; v = (s > 127) || (s < -128); end
      4'd3: r = ua & ub;
      4'd4: r = ua | ub;
      4'd5: r = ua ^ ub;
      4'd6: r = 255 - ua;
      4'd7: r = (ub >= 8) ? 0 : ua * (2 ** ub);
      4'd8: r = (ub >= 8) ? 0 : ua / (2 ** ub);
      4'd9: r = (ua == ub) ? 1 : 0;
      4'd10: begin p = ua * ub; r = p % 256; e.h = p[15:8]; c = (p >= 256); end
      4'd11: r = (ua < ub) ? 1 : 0;
      default: er = 1'b1;
    endcase
    r = ((r % 256) + 256) % 256;
    if (er) begin
      z = 1'b0; n = 1'b0;
    end else begin
      z = (o == 4'd10) ? (p == 0) : (r == 0);
      n = (r >= 128);
    end
    e.r   = r[7:0];
    e.f   = {z, c, n, v, er};
    e.due = now + ((o == 4'd10) ? 9 : 1);
    return e;
  endfunction

  // Cycle counter; monitoring starts once a reset edge has been seen
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) armed <= 1'b1;
  end

  // Monitor: compare DUT against the model, then advance the model for the next edge
  always @(negedge clk) begin
    if (armed) begin
      busy_m = (q.size() != 0);
      ov_m   = busy_m && (cyc >= q[0].due);
      chk("mon_in_ready", in_ready, !busy_m);
      chk("mon_out_valid", out_valid, ov_m);
      if (ov_m) begin
        chk("mon_result", result, q[0].r);
        chk("mon_result_hi", result_hi, q[0].h);
        chk("mon_flags", flags, q[0].f);
      end
      if (rst) begin
        q.delete();
      end else begin
        if (ov_m && out_ready) void'(q.pop_front());
        if (!busy_m && in_valid) q.push_back(model(op, a, b, cyc));
      end
    end
  end

  // Issue one op, check literal expectations, optionally stall the sink, then drain
  task automatic run_op(input string nm, input logic [3:0] o, input logic [7:0] xa,
                        input logic [7:0] xb, input int hold, input logic [7:0] er,
                        input logic [7:0] eh, input logic [4:0] ef);
    bit got;
    @(posedge clk); #1;
    op = o; a = xa; b = xb; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 4'd1; a = 8'($urandom); b = 8'($urandom);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin got = 1'b1; break; end
    end
    chk({nm, "_valid"}, got, 1'b1);
    chk({nm, "_result"}, result, er);
    chk({nm, "_result_hi"}, result_hi, eh);
    chk({nm, "_flags"}, flags, ef);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; op = 4'd4; a = 8'hFF; b = 8'hFF;  // must be ignored
    end
    if (hold > 0) begin
      @(negedge clk);
      chk({nm, "_held_result"}, result, er);
      chk({nm, "_held_in_ready"}, in_ready, 1'b0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({nm, "_after_in_ready"}, in_ready, 1'b1);
    chk({nm, "_after_out_valid"}, out_valid, 1'b0);
  endtask

  initial begin
    bit saw;
    rst = 1'b1; in_valid = 1'b1; op = 4'd1; a = 8'hFF; b = 8'h01; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, 8'h00);
    chk("rst_result_hi", result_hi, 8'h00);
    chk("rst_flags", flags, 5'b00000);

    run_op("add_wrap", 4'd1,  8'hFF, 8'h01, 0, 8'h00, 8'h00, 5'b11000);
    run_op("add_ovf",  4'd1,  8'h7F, 8'h01, 0, 8'h80, 8'h00, 5'b00110);
    run_op("sub_brw",  4'd2,  8'h03, 8'h05, 0, 8'hFE, 8'h00, 5'b01100);
    run_op("sub_ovf",  4'd2,  8'h80, 8'h01, 0, 8'h7F, 8'h00, 5'b00010);
    run_op("shl_big",  4'd7,  8'h01, 8'h09, 0, 8'h00, 8'h00, 5'b10000);
    run_op("shl_7",    4'd7,  8'h01, 8'h07, 0, 8'h80, 8'h00, 5'b00100);
    run_op("shr_7",    4'd8,  8'h80, 8'h07, 0, 8'h01, 8'h00, 5'b00000);
    run_op("shr_8",    4'd8,  8'h80, 8'h08, 0, 8'h00, 8'h00, 5'b10000);
    run_op("or",       4'd4,  8'h0F, 8'h30, 0, 8'h3F, 8'h00, 5'b00000);
    run_op("xor_z",    4'd5,  8'hAA, 8'hAA, 0, 8'h00, 8'h00, 5'b10000);
    run_op("not",      4'd6,  8'h0F, 8'h00, 0, 8'hF0, 8'h00, 5'b00100);
    run_op("eq",       4'd9,  8'h5A, 8'h5A, 0, 8'h01, 8'h00, 5'b00000);
    run_op("mul_ff",   4'd10, 8'hFF, 8'hFF, 0, 8'h01, 8'hFE, 5'b01000);
    run_op("mul_hi",   4'd10, 8'h10, 8'h10, 0, 8'h00, 8'h01, 5'b01000);
    run_op("mul_zero", 4'd10, 8'h00, 8'h37, 0, 8'h00, 8'h00, 5'b10000);
    run_op("ill14",    4'd14, 8'h12, 8'h34, 0, 8'h00, 8'h00, 5'b00001);
    run_op("ill0",     4'd0,  8'h12, 8'h34, 0, 8'h00, 8'h00, 5'b00001);
    run_op("ltu",      4'd11, 8'h02, 8'h03, 0, 8'h01, 8'h00, 5'b00000);
    run_op("and_bp",   4'd3,  8'hF0, 8'h3C, 5, 8'h30, 8'h00, 5'b00000);

    // Multiply aborted by reset: accept edge, then rst seen on the fourth edge after
    @(posedge clk); #1;
    op = 4'd10; a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 4'd2; a = 8'h11; b = 8'h22;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_result", result, 8'h00);
    saw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    chk("abort_no_valid", saw, 1'b0);

    run_op("post_rst_mul", 4'd10, 8'h0D, 8'h0B, 0, 8'h8F, 8'h00, 5'b00100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete (n_fail=%0d)", n_fail);
    $fatal(1, "timeout");
  end

endmodule
